// File: rtl/memory_pkg.sv
// Shared definitions for the memory test app: checker state encodings,
// default RAM geometry and the writer's arithmetic pattern constants, kept
// in one place so the pattern writer and the read checker cannot drift.
package memory_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 10;

  localparam logic [7:0] WRITER_SEED       = 8'h00;
  localparam logic [7:0] WRITER_STEP       = 8'h03;
  localparam logic [9:0] WRITER_RESET_ADDR = 10'h000;

  typedef enum logic [1:0] {
    STATE_IDLE  = 2'd0,
    STATE_ISSUE = 2'd1,
    STATE_DRAIN = 2'd2,
    STATE_DONE  = 2'd3
  } checker_state_t;

endpackage

// File: rtl/mem_read_checker_tag_pipe.sv
// read_tag_pipe: fixed-depth shift register that carries a tag alongside each
// outstanding RAM read so it lines up with the returning data. Only the valid
// bits are reset; payload bits are don't-care while their valid bit is low.
module read_tag_pipe #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 18
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_payload,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_payload,
  output logic             upstream_valid
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] payload_q [DEPTH];

  // Shift the valid bits one stage per clock, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // Shift the tag payload alongside the valid bits; no reset needed.
  always_ff @(posedge clock) begin
    payload_q[0] <= in_payload;
    for (int i = 1; i < DEPTH; i++) begin
      payload_q[i] <= payload_q[i-1];
    end
  end

  // Flag any tag not yet at the output stage, so the owner can tell the
  // pipe will be empty after the current output is consumed.
  always_comb begin
    upstream_valid = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      upstream_valid = upstream_valid | valid_q[i];
    end
  end

  assign out_valid   = valid_q[DEPTH-1];
  assign out_payload = payload_q[DEPTH-1];

endmodule

// File: rtl/mem_read_checker.sv
// mem_read_checker: streams sequential reads from one RAM port and compares
// each word against the writer's arithmetic pattern (seed + step*i), counting
// mismatches and capturing the first failing address/data.
// Optional build macro CHECKER_STOP_ON_ERROR_EN: the first mismatch stops
// further reads; reads already in flight are still checked.
module mem_read_checker
  import memory_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int READ_LATENCY = 2,
  parameter int DATA_STEP    = int'(WRITER_STEP)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  ram_enable,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   error_count,
  output logic                  first_err_valid,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [DATA_WIDTH-1:0] first_err_data
);

  localparam int COUNT_WIDTH = ADDR_WIDTH + 1;
  localparam int TAG_WIDTH   = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(DATA_STEP);

  checker_state_t state, state_next;

  logic [ADDR_WIDTH-1:0]  addr_reg;
  logic [DATA_WIDTH-1:0]  expect_reg;
  logic [COUNT_WIDTH-1:0] remaining;

  logic                  tag_valid;
  logic [TAG_WIDTH-1:0]  tag_payload;
  logic                  tag_upstream;
  logic [ADDR_WIDTH-1:0] tag_addr;
  logic [DATA_WIDTH-1:0] tag_expect;

  logic mismatch;
  logic stop_now;
  logic last_issue;
  logic accept_start;

  assign {tag_addr, tag_expect} = tag_payload;
  assign mismatch     = tag_valid && (ram_rdata != tag_expect);
  assign last_issue   = (remaining == COUNT_WIDTH'(1));
  assign accept_start = (state == STATE_IDLE) && start;
  assign ram_addr     = addr_reg;

`ifdef CHECKER_STOP_ON_ERROR_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  read_tag_pipe #(
    .DEPTH (READ_LATENCY),
    .WIDTH (TAG_WIDTH)
  ) u_tag_pipe (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (ram_enable),
    .in_payload     ({addr_reg, expect_reg}),
    .out_valid      (tag_valid),
    .out_payload    (tag_payload),
    .upstream_valid (tag_upstream)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= STATE_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: DRAIN leaves once the last outstanding tag is being
  // compared, so the final comparison and done line up.
  always_comb begin
    state_next = state;
    case (state)
      STATE_IDLE: begin
        if (start) begin
          state_next = (word_count == '0) ? STATE_DONE : STATE_ISSUE;
        end
      end
      STATE_ISSUE: begin
        if (stop_now || last_issue) begin
          state_next = STATE_DRAIN;
        end
      end
      STATE_DRAIN: begin
        if (!tag_upstream) begin
          state_next = STATE_DONE;
        end
      end
      STATE_DONE: begin
        state_next = STATE_IDLE;
      end
      default: begin
        state_next = STATE_IDLE;
      end
    endcase
  end

  // Moore-style outputs; the read strobe is also withheld on a stopping error.
  always_comb begin
    ram_enable = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      STATE_ISSUE: begin
        ram_enable = !stop_now;
        busy       = 1'b1;
      end
      STATE_DRAIN: begin
        busy = 1'b1;
      end
      STATE_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Address/expected-data generators and run counter, stepped by addition.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_reg   <= '0;
      expect_reg <= '0;
      remaining  <= '0;
    end else if (accept_start) begin
      addr_reg   <= start_addr;
      expect_reg <= seed;
      remaining  <= word_count;
    end else if (ram_enable) begin
      addr_reg   <= addr_reg + ADDR_WIDTH'(1);
      expect_reg <= expect_reg + STEP;
      remaining  <= remaining - COUNT_WIDTH'(1);
    end
  end

  // Result registers: cleared on an accepted start, updated per compare,
  // and pass resolved on entry to DONE including the last compare.
  always_ff @(posedge clock) begin
    if (reset) begin
      pass            <= 1'b0;
      error_count     <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
      first_err_data  <= '0;
    end else if (accept_start) begin
      pass            <= (word_count == '0);
      error_count     <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
      first_err_data  <= '0;
    end else begin
      if (mismatch) begin
        if (error_count != '1) begin
          error_count <= error_count + COUNT_WIDTH'(1);
        end
        if (!first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_addr  <= tag_addr;
          first_err_data  <= ram_rdata;
        end
      end
      if ((state == STATE_DRAIN) && (state_next == STATE_DONE)) begin
        pass <= (error_count == '0) && !mismatch;
      end
    end
  end

endmodule
